bsg_bladerunner_rom_reader: RTL and testbench
=============================================

BSG_BLADERUNNER_ROM_READER -- requirements
Module: bsg_bladerunner_rom_reader

Interface
REQ-001 SHALL have parameter rom_els_p, default "inv": number of ROM words readable; maximum count.
REQ-002 SHALL have parameter data_width_p, default "inv": width of returned ROM data.
REQ-003 SHALL have parameter addr_width_p, default "inv": width of the remote word address.
REQ-004 SHALL have parameter load_id_width_p, default "inv": width of the network load id.
REQ-005 SHALL have parameter max_out_p, default 4: outstanding loads and reorder slots; power of 2, at most 2^load_id_width_p.
REQ-006 SHALL have port clk_i, input, 1: single clock.
REQ-007 SHALL have port reset_i, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start_v_i, input, 1: start a read burst.
REQ-009 SHALL have port start_ready_o, output, 1: high only in IDLE.
REQ-010 SHALL have port base_addr_i, input, addr_width_p: first ROM word address.
REQ-011 SHALL have port count_i, input, clog2(rom_els_p+1): words to read.
REQ-012 SHALL have ports out_v_o (output, 1), out_addr_o (output, addr_width_p), out_load_id_o (output, load_id_width_p) and out_ready_i (input, 1): load request towards the endpoint.
REQ-013 SHALL have ports returned_v_i (input, 1), returned_data_i (input, data_width_p), returned_load_id_i (input, load_id_width_p) and returned_yumi_o (output, 1): load responses.
REQ-014 SHALL have ports v_o (output, 1), data_o (output, data_width_p) and yumi_i (input, 1): in-order data stream.
REQ-015 SHALL have ports done_o (output, 1, one-cycle pulse) and error_o (output, 1, sticky).

Function
REQ-016 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-017 In IDLE, start_v_i SHALL latch base_addr_i and count_i; count 0 SHALL pulse done_o next cycle and stay in IDLE; count >0 SHALL enter ISSUE.
REQ-018 Each slot SHALL hold one of EMPTY, PENDING or FULL plus one data word.
REQ-019 out_v_o SHALL be high in ISSUE when slot[issue_idx mod max_out_p] is EMPTY (registered state).
REQ-020 out_addr_o SHALL equal base + issue_idx, truncated to addr_width_p; out_load_id_o SHALL be the zero-extended slot index.
REQ-021 When out_v_o and out_ready_i are both high, the slot SHALL become PENDING and issue_idx SHALL increment.
REQ-022 When issue_idx reaches count, the block SHALL enter DRAIN.
REQ-023 returned_yumi_o SHALL equal returned_v_i.
REQ-024 A response to a PENDING slot SHALL store its data and set the slot FULL; responses may arrive in any order.
REQ-025 A response to a non-PENDING slot, or with load_id >= max_out_p, SHALL be dropped and SHALL set error_o.
REQ-026 v_o SHALL be high when slot[drain_ptr] is FULL, with data_o equal to that slot's data.
REQ-027 yumi_i SHALL set the slot EMPTY and increment drain_ptr (mod max_out_p) and the delivered count; yumi_i without v_o SHALL set error_o.
REQ-028 A slot freed in cycle t SHALL NOT be reissued before cycle t+1.
REQ-029 A response and a drain to different slots in the same cycle SHALL both take effect.
REQ-030 An issue and a response in the same cycle SHALL both take effect.
REQ-031 When delivered equals count, done_o SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-032 Minimum latency SHALL be: request in cycle t, response in cycle t+k, v_o in cycle t+k+1.

Reset
REQ-033 During reset_i, the block SHALL set state IDLE, all slots EMPTY, all counters and pointers 0, and out_v_o, v_o, done_o and error_o all 0.
REQ-034 Reset mid-burst SHALL abandon the burst; responses to loads issued before reset SHALL be dropped, acknowledged and flagged on error_o.

Structure
REQ-035 The slot-state enum and the state-machine enum SHALL reside in bsg_bladerunner_rom_pkg.
REQ-036 Slot storage SHALL be a single sub-module, bsg_mem_1r1w (max_out_p x data_width_p), written on response and read at drain_ptr; slot states SHALL remain in flops.

Verification
REQ-037 Directed test: max_out_p=4, count=8, base=0x10, out_ready_i always high, in-order responses, yumi_i always high -> addresses 0x10..0x17 with ids 0,1,2,3,0,..., data in order, done_o pulses once.
REQ-038 Directed test: responses for ids 3,1,0,2 -> v_o stays low until id 0 returns, then data emerges in address order.
REQ-039 Directed test: yumi_i held low with 4 loads outstanding -> out_v_o low, no fifth request until one yumi_i, then request on the next cycle.
REQ-040 Directed test: count=0 -> no out_v_o, done_o one cycle after start, start_ready_o stays high.
REQ-041 Directed test: reset after 2 of 6 issues, then a late response with id 1 -> returned_yumi_o high, no v_o, error_o=1.
REQ-042 Directed test: out_ready_i toggled randomly -> out_addr_o and out_load_id_o stable while out_v_o is high and not accepted; no duplicate addresses.

Source files
------------

// File: rtl/bsg_bladerunner_rom_pkg.sv
// Shared types for the ROM reader: per-slot reorder state and the burst controller state.
package bsg_bladerunner_rom_pkg;

  typedef enum logic [1:0] {
    e_slot_empty   = 2'd0,
    e_slot_pending = 2'd1,
    e_slot_full    = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_issue = 2'd1,
    e_drain = 2'd2
  } reader_state_e;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Reorder data storage: one synchronous write port, one asynchronous read port.
// Read data reflects a write on the cycle after it lands.
module bsg_mem_1r1w #(
  parameter width_p = "inv",
  parameter els_p   = "inv",
  localparam addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_bladerunner_rom_reader.sv
// Issues up to max_out_p ROM loads, accepts responses in any order, streams data in address order.
// Request stalls while its reorder slot is occupied; response-to-v_o latency is one cycle.
module bsg_bladerunner_rom_reader
  import bsg_bladerunner_rom_pkg::*;
#(
  parameter rom_els_p       = "inv",
  parameter data_width_p    = "inv",
  parameter addr_width_p    = "inv",
  parameter load_id_width_p = "inv",
  parameter max_out_p       = 4,
  localparam count_width_lp = $clog2(rom_els_p + 1),
  localparam slot_width_lp  = (max_out_p > 1) ? $clog2(max_out_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       start_v_i,
  output logic                       start_ready_o,
  input  logic [addr_width_p-1:0]    base_addr_i,
  input  logic [count_width_lp-1:0]  count_i,

  output logic                       out_v_o,
  output logic [addr_width_p-1:0]    out_addr_o,
  output logic [load_id_width_p-1:0] out_load_id_o,
  input  logic                       out_ready_i,

  input  logic                       returned_v_i,
  input  logic [data_width_p-1:0]    returned_data_i,
  input  logic [load_id_width_p-1:0] returned_load_id_i,
  output logic                       returned_yumi_o,

  output logic                       v_o,
  output logic [data_width_p-1:0]    data_o,
  input  logic                       yumi_i,

  output logic                       done_o,
  output logic                       error_o
);

  reader_state_e state_q, state_d;
  slot_state_e   slot_q [max_out_p];
  slot_state_e   slot_d [max_out_p];

  logic [addr_width_p-1:0]   base_q, base_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic [count_width_lp-1:0] issue_idx_q, issue_idx_d;
  logic [count_width_lp-1:0] delivered_q, delivered_d;
  logic [slot_width_lp-1:0]  drain_ptr_q, drain_ptr_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic [slot_width_lp-1:0]  issue_slot;
  logic [slot_width_lp-1:0]  ret_slot;
  logic                      id_in_range;
  logic                      ret_accept;
  logic                      issue_fire;
  logic                      drain_fire;

  assign issue_slot  = (max_out_p == 1) ? '0 : slot_width_lp'(issue_idx_q);
  assign ret_slot    = (max_out_p == 1) ? '0 : slot_width_lp'(returned_load_id_i);
  // Widened compare so max_out_p == 2**load_id_width_p does not wrap to zero.
  assign id_in_range = {1'b0, returned_load_id_i} < (load_id_width_p + 1)'(max_out_p);
  assign ret_accept  = returned_v_i & id_in_range & (slot_q[ret_slot] == e_slot_pending);

  assign start_ready_o   = (state_q == e_idle);
  assign out_v_o         = ~reset_i & (state_q == e_issue) & (slot_q[issue_slot] == e_slot_empty);
  assign out_addr_o      = base_q + addr_width_p'(issue_idx_q);
  assign out_load_id_o   = load_id_width_p'(issue_slot);
  assign returned_yumi_o = returned_v_i;
  assign v_o             = ~reset_i & (slot_q[drain_ptr_q] == e_slot_full);
  assign done_o          = done_q;
  assign error_o         = error_q;

  assign issue_fire = out_v_o & out_ready_i;
  assign drain_fire = v_o & yumi_i;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    base_d      = base_q;
    count_d     = count_q;
    issue_idx_d = issue_idx_q;
    delivered_d = delivered_q;
    drain_ptr_d = drain_ptr_q;
    done_d      = 1'b0;
    error_d     = error_q;

    // Issue, response and drain always touch slots in distinct states, so all three can apply.
    if (drain_fire) begin
      slot_d[drain_ptr_q] = e_slot_empty;
      drain_ptr_d         = (max_out_p == 1) ? '0 : drain_ptr_q + slot_width_lp'(1);
      delivered_d         = delivered_q + count_width_lp'(1);
    end
    if (ret_accept) begin
      slot_d[ret_slot] = e_slot_full;
    end
    if ((returned_v_i & ~ret_accept) | (yumi_i & ~v_o)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      e_idle: begin
        if (start_v_i) begin
          base_d      = base_addr_i;
          count_d     = count_i;
          issue_idx_d = '0;
          delivered_d = '0;
          drain_ptr_d = '0;
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = e_issue;
          end
        end
      end
      e_issue: begin
        if (issue_fire) begin
          slot_d[issue_slot] = e_slot_pending;
          issue_idx_d        = issue_idx_q + count_width_lp'(1);
          if (issue_idx_d == count_q) begin
            state_d = e_drain;
          end
        end
      end
      e_drain: begin
        if (drain_fire && (delivered_d == count_q)) begin
          done_d  = 1'b1;
          state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      base_q      <= '0;
      count_q     <= '0;
      issue_idx_q <= '0;
      delivered_q <= '0;
      drain_ptr_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      for (int i = 0; i < max_out_p; i++) begin
        slot_q[i] <= e_slot_empty;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issue_idx_q <= issue_idx_d;
      delivered_q <= delivered_d;
      drain_ptr_q <= drain_ptr_d;
      done_q      <= done_d;
      error_q     <= error_d;
      for (int i = 0; i < max_out_p; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  bsg_mem_1r1w #(
    .width_p (data_width_p),
    .els_p   (max_out_p)
  ) slot_mem (
    .clk_i    (clk_i),
    .w_v_i    (ret_accept),
    .w_addr_i (ret_slot),
    .w_data_i (returned_data_i),
    .r_addr_i (drain_ptr_q),
    .r_data_o (data_o)
  );

endmodule

// File: tb/tb_bsg_bladerunner_rom_reader.sv
// Directed bench for the ROM reader with a modelled load endpoint and an in-order data scoreboard.
module tb_bsg_bladerunner_rom_reader;

  localparam int ROM_ELS = 16;
  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int LW      = 4;
  localparam int MO      = 4;
  localparam int CW      = $clog2(ROM_ELS + 1);

  logic          clk;
  logic          reset_i;
  logic          start_v_i;
  logic          start_ready_o;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] count_i;
  logic          out_v_o;
  logic [AW-1:0] out_addr_o;
  logic [LW-1:0] out_load_id_o;
  logic          out_ready_i;
  logic          returned_v_i;
  logic [DW-1:0] returned_data_i;
  logic [LW-1:0] returned_load_id_i;
  logic          returned_yumi_o;
  logic          v_o;
  logic [DW-1:0] data_o;
  logic          yumi_i;
  logic          done_o;
  logic          error_o;

  bsg_bladerunner_rom_reader #(
    .rom_els_p       (ROM_ELS),
    .data_width_p    (DW),
    .addr_width_p    (AW),
    .load_id_width_p (LW),
    .max_out_p       (MO)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .start_v_i          (start_v_i),
    .start_ready_o      (start_ready_o),
    .base_addr_i        (base_addr_i),
    .count_i            (count_i),
    .out_v_o            (out_v_o),
    .out_addr_o         (out_addr_o),
    .out_load_id_o      (out_load_id_o),
    .out_ready_i        (out_ready_i),
    .returned_v_i       (returned_v_i),
    .returned_data_i    (returned_data_i),
    .returned_load_id_i (returned_load_id_i),
    .returned_yumi_o    (returned_yumi_o),
    .v_o                (v_o),
    .data_o             (data_o),
    .yumi_i             (yumi_i),
    .done_o             (done_o),
    .error_o            (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [LW-1:0] exp_id_q   [$];
  logic [DW-1:0] exp_data_q [$];

  logic [LW-1:0] pend_q [$];
  logic          pend_v    [MO];
  logic [AW-1:0] pend_addr [MO];

  int rdy_mode, yumi_mode;
  bit hold_resp, man_mode;
  int man_order [4];
  int man_n, man_i;
  int req_cnt, v_cnt, done_cnt, outv_cnt;
  int first_req_cyc, first_v_cyc, resp0_cyc;
  bit prev_stall;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_id;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id);
    returned_v_i       = 1'b1;
    returned_load_id_i = LW'(id);
    returned_data_i    = rom(pend_addr[id]);
    pend_v[id]         = 1'b0;
    if (id == 0) resp0_cyc = cyc;
  endtask

  // One clock: endpoint and consumer drive at the falling edge, outputs are checked 1ns later.
  task automatic cycle();
    logic [AW-1:0] ea;
    logic [LW-1:0] ei;
    @(negedge clk);
    cyc++;
    returned_v_i       = 1'b0;
    returned_load_id_i = '0;
    returned_data_i    = '0;
    if (!hold_resp) begin
      if (man_mode) begin
        if (man_i < man_n && pend_v[man_order[man_i]]) begin
          send(man_order[man_i]);
          man_i++;
        end
      end else if (pend_q.size() > 0) begin
        send(int'(pend_q.pop_front()));
      end
    end
    out_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    yumi_i      = ((yumi_mode == 2) ? 1'($urandom_range(0, 1)) : (yumi_mode == 1)) & v_o;
    #1;
    if (returned_v_i) chk("ret_yumi", returned_yumi_o, 1);
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("req_hold_v", out_v_o, 1);
        chk("req_hold_addr", out_addr_o, prev_addr);
        chk("req_hold_id", out_load_id_o, prev_id);
      end
      if (out_v_o) outv_cnt++;
      if (out_v_o && out_ready_i) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        req_cnt++;
        chk("req_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          ei = exp_id_q.pop_front();
          chk("req_addr", out_addr_o, ea);
          chk("req_id", out_load_id_o, ei);
        end
        if (out_load_id_o < MO) begin
          pend_v[out_load_id_o]    = 1'b1;
          pend_addr[out_load_id_o] = out_addr_o;
          pend_q.push_back(out_load_id_o);
        end
      end
      prev_stall = out_v_o && !out_ready_i;
      prev_addr  = out_addr_o;
      prev_id    = out_load_id_o;
      if (v_o) begin
        v_cnt++;
        if (first_v_cyc < 0) first_v_cyc = cyc;
      end
      if (v_o && yumi_i) begin
        chk("data_expected", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) chk("data", data_o, exp_data_q.pop_front());
      end
      if (done_o) done_cnt++;
    end
  endtask

  task automatic start(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_id_q.push_back(LW'(i % MO));
      exp_data_q.push_back(rom(a));
    end
    base_addr_i = base;
    count_i     = CW'(n);
    start_v_i   = 1'b1;
    cycle();
    start_v_i   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cycle();
    chk({tag, "_done"}, done_cnt - d0, 1);
    cycle();
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_sb_empty"}, exp_addr_q.size() + exp_data_q.size(), 0);
  endtask

  initial begin
    int r0, o0, v0;
    reset_i = 1'b1; start_v_i = 1'b0; base_addr_i = '0; count_i = '0;
    out_ready_i = 1'b0; returned_v_i = 1'b0; returned_data_i = '0;
    returned_load_id_i = '0; yumi_i = 1'b0;
    rdy_mode = 1; yumi_mode = 1; hold_resp = 1'b0; man_mode = 1'b0;
    man_order = '{3, 1, 0, 2}; man_n = 0; man_i = 0;
    req_cnt = 0; v_cnt = 0; done_cnt = 0; outv_cnt = 0;
    first_req_cyc = -1; first_v_cyc = -1; resp0_cyc = -1;
    prev_stall = 1'b0; prev_addr = '0; prev_id = '0;
    for (int i = 0; i < MO; i++) begin pend_v[i] = 1'b0; pend_addr[i] = '0; end

    repeat (3) cycle();
    chk("rst_ready", start_ready_o, 1);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_v", v_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    reset_i = 1'b0;
    cycle();

    // In-order burst of 8 over 4 slots.
    start(16'h0010, 8);
    wait_done("A", 100);
    chk("A_latency", first_v_cyc - first_req_cyc, 2);
    chk("A_ready", start_ready_o, 1);

    // Out-of-order returns 3,1,0,2.
    man_mode = 1'b1; man_order = '{3, 1, 0, 2}; man_n = 4; man_i = 0;
    first_v_cyc = -1; resp0_cyc = -1;
    start(16'h0040, 4);
    wait_done("B", 100);
    chk("B_v_after_id0", first_v_cyc, resp0_cyc + 1);
    chk("B_error", error_o, 0);
    man_mode = 1'b0;

    // Consumer stalled with every slot occupied.
    yumi_mode = 0; r0 = req_cnt;
    start(16'h0080, 8);
    repeat (12) cycle();
    chk("C_stall_outv", out_v_o, 0);
    chk("C_issued", req_cnt - r0, 4);
    chk("C_v", v_o, 1);
    yumi_mode = 1;
    cycle();
    chk("C_no_same_cycle", out_v_o, 0);
    yumi_mode = 0;
    cycle();
    chk("C_reissue", out_v_o, 1);
    yumi_mode = 1;
    wait_done("C", 100);

    // Zero-length burst.
    o0 = outv_cnt;
    start(16'h0033, 0);
    chk("D_done", done_o, 1);
    chk("D_ready", start_ready_o, 1);
    cycle();
    chk("D_done_once", done_o, 0);
    chk("D_no_req", outv_cnt - o0, 0);
    chk("D_ready2", start_ready_o, 1);

    // Reset mid-burst, then a stale response.
    hold_resp = 1'b1; r0 = req_cnt;
    start(16'h0020, 6);
    for (int i = 0; i < 20 && req_cnt - r0 < 2; i++) cycle();
    rdy_mode = 0;
    cycle();
    chk("E_issued", req_cnt - r0, 2);
    reset_i = 1'b1;
    repeat (2) cycle();
    reset_i = 1'b0;
    cycle();
    chk("E_err_after_reset", error_o, 0);
    chk("E_idle", start_ready_o, 1);
    exp_addr_q.delete(); exp_id_q.delete(); exp_data_q.delete(); pend_q.delete();
    man_mode = 1'b1; man_order[0] = 1; man_n = 1; man_i = 0; hold_resp = 1'b0;
    v0 = v_cnt;
    cycle();
    chk("E_ret_yumi", returned_yumi_o, 1);
    cycle();
    chk("E_error", error_o, 1);
    chk("E_no_v", v_cnt - v0, 0);
    man_mode = 1'b0;
    for (int i = 0; i < MO; i++) pend_v[i] = 1'b0;
    reset_i = 1'b1;
    repeat (2) cycle();
    reset_i = 1'b0;
    rdy_mode = 1;
    cycle();
    chk("E_error_cleared", error_o, 0);

    // Full-size burst wrapping the address space, random ready and yumi.
    rdy_mode = 2; yumi_mode = 2;
    start(16'hFFF8, 16);
    wait_done("F", 400);
    chk("F_error", error_o, 0);
    rdy_mode = 1; yumi_mode = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
